// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter states and
// default bus widths used by the arbiter and its command multiplexer.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_BA_W   = 2;
    localparam int SDRAM_DQ_W   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_READ         = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_A_REF = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational selection of the SDRAM command/bank/address bus according to
// the current arbiter owner; an idle bus carries NOP with all-ones bank/address.
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int BA_W   = SDRAM_BA_W
) (
    input  arb_state_t        state,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        a_ref_cmd,
    input  logic [BA_W-1:0]   a_ref_ba,
    input  logic [ADDR_W-1:0] a_ref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        cmd,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        cmd  = CMD_NOP;
        ba   = '1;
        addr = '1;
        case (state)
            ST_INIT: begin
                cmd  = init_cmd;
                ba   = init_ba;
                addr = init_addr;
            end
            ST_A_REF: begin
                cmd  = a_ref_cmd;
                ba   = a_ref_ba;
                addr = a_ref_addr;
            end
            ST_WRITE: begin
                cmd  = wr_cmd;
                ba   = wr_ba;
                addr = wr_addr;
            end
            ST_READ: begin
                cmd  = rd_cmd;
                ba   = rd_ba;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init owns the bus until init_end, then refresh has strict
// priority and write/read alternate round-robin, one owner at a time.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int BA_W   = SDRAM_BA_W,
    parameter int DQ_W   = SDRAM_DQ_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              a_ref_req,
    input  logic              a_ref_end,
    input  logic [3:0]        a_ref_cmd,
    input  logic [BA_W-1:0]   a_ref_ba,
    input  logic [ADDR_W-1:0] a_ref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              a_ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_rd;
    logic [3:0] cmd_sel;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_INIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (init_end) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
                if (a_ref_req)           state_nxt = ST_A_REF;
                else if (wr_req && rd_req) state_nxt = last_rd ? ST_WRITE : ST_READ;
                else if (wr_req)         state_nxt = ST_WRITE;
                else if (rd_req)         state_nxt = ST_READ;
            end
            ST_A_REF: if (a_ref_end) state_nxt = ST_ARBIT;
            ST_WRITE: if (wr_end)    state_nxt = ST_ARBIT;
            ST_READ:  if (rd_end)    state_nxt = ST_ARBIT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Remembers which of write/read finished last so contention alternates.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                            last_rd <= 1'b0;
        else if (state == ST_READ  && rd_end)   last_rd <= 1'b1;
        else if (state == ST_WRITE && wr_end)   last_rd <= 1'b0;
    end

    assign a_ref_en     = (state == ST_A_REF);
    assign wr_en        = (state == ST_WRITE);
    assign rd_en        = (state == ST_READ);
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = wr_sdram_en && (state == ST_WRITE);
    assign sdram_dq_out = (state == ST_WRITE) ? wr_sdram_data : '0;

    sdram_cmd_mux #(
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W)
    ) u_cmd_mux (
        .state      (state),
        .init_cmd   (init_cmd),
        .init_ba    (init_ba),
        .init_addr  (init_addr),
        .a_ref_cmd  (a_ref_cmd),
        .a_ref_ba   (a_ref_ba),
        .a_ref_addr (a_ref_addr),
        .wr_cmd     (wr_cmd),
        .wr_ba      (wr_ba),
        .wr_addr    (wr_addr),
        .rd_cmd     (rd_cmd),
        .rd_ba      (rd_ba),
        .rd_addr    (rd_addr),
        .cmd        (cmd_sel),
        .ba         (sdram_ba),
        .addr       (sdram_addr)
    );

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

SDRAM bus arbiter and command multiplexer for the controller top level. It holds the bus for the initialization module until `init_end`, then shares the command/address/data bus between the auto-refresh, write and read sub-modules. It grants one owner at a time through per-requester enables and releases the bus on that requester's end pulse. Auto-refresh always wins; write and read alternate round-robin.

## Interface
- `ADDR_W`, 13: SDRAM address width (A12..A0)
- `BA_W`, 2: bank address width
- `DQ_W`, 16: data bus width
- `sys_clk` in 1: system clock, 100 MHz
- `sys_rst` in 1: asynchronous, active-high reset
- `init_end` in 1: initialization done (level)
- `init_cmd` in 4, `init_ba` in 2, `init_addr` in 13: init phase {cs_n,ras_n,cas_n,we_n}, bank, address
- `a_ref_req` in 1: refresh request (level, held until refresh starts)
- `a_ref_end` in 1: refresh done (1-cycle pulse)
- `a_ref_cmd` in 4, `a_ref_ba` in 2, `a_ref_addr` in 13: refresh-phase bus
- `wr_req` in 1, `wr_end` in 1, `wr_cmd` in 4, `wr_ba` in 2, `wr_addr` in 13: write requester
- `wr_sdram_en` in 1, `wr_sdram_data` in 16: write data drive enable and data
- `rd_req` in 1, `rd_end` in 1, `rd_cmd` in 4, `rd_ba` in 2, `rd_addr` in 13: read requester
- `a_ref_en` out 1, `wr_en` out 1, `rd_en` out 1: grants (one-hot or zero)
- `sdram_cke` out 1: clock enable
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: command pins
- `sdram_ba` out 2, `sdram_addr` out 13: bank and address pins
- `sdram_dq_out` out 16, `sdram_dq_oe` out 1: DQ output data and output enable (tristate at pad level)

## Operation
- FSM states: INIT, ARBIT, A_REF, WRITE, READ. Reset enters INIT.
- INIT: bus = init bus. Move to ARBIT on `init_end`.
- ARBIT: bus = NOP, ba 2'b11, addr 13'h1fff. Priority is evaluated every cycle:
  - `a_ref_req` -> A_REF
  - else `wr_req` and `rd_req` both high -> WRITE if `last_rd`=1, else READ
  - else `wr_req` -> WRITE
  - else `rd_req` -> READ
  - else stay in ARBIT
- A_REF, WRITE, READ: bus = that requester's cmd/ba/addr. Return to ARBIT on the matching end pulse. End pulses from other requesters are ignored.
- `last_rd` flag: set on READ exit, cleared on WRITE exit, reset 0. After reset with both requests pending, READ is granted first.
- Grants are decoded from state: `a_ref_en`=(A_REF), `wr_en`=(WRITE), `rd_en`=(READ). All are 0 in INIT and ARBIT.
- A request arriving mid-burst is not granted until the current owner ends. This covers a refresh request during a write or read.
- `sdram_dq_oe` = `wr_sdram_en` && WRITE state. `sdram_dq_out` = `wr_sdram_data` in WRITE, else 0.
- `sdram_cke` is constant 1. `sdram_cs_n`/`ras_n`/`cas_n`/`we_n` = the selected cmd[3:0].
- Reset mid-operation: asynchronous return to INIT, with all grants and `sdram_dq_oe` low immediately.

## Timing
- Output mux is combinational from the state register and requester buses, adding zero cycles of latency.
- Reset values:
  - state INIT, `last_rd` 0
  - grants 0, `sdram_dq_oe` 0, `sdram_dq_out` 0, `sdram_cke` 1
  - command/ba/addr equal the init bus (the init module drives NOP/2'b11/13'h1fff in reset)
- Request to grant: request high in ARBIT at edge N, grant high from cycle N+1.
- End to release: end pulse at edge M, grant low and NOP on bus from cycle M+1. The earliest next grant is M+2.
- Minimum gap between owners is one ARBIT cycle of NOP.
- `init_end` rising at edge K: ARBIT from K+1. A refresh pending at K+1 is granted at K+2.

## Structure
- Shared package `sdram_pkg` holds:
  - command encodings NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001, ACTIVE 4'b0011, WRITE 4'b0100, READ 4'b0101
  - arbiter state typedef
  - `ADDR_W`/`BA_W`/`DQ_W` defaults
- Sub-module `sdram_cmd_mux`: 4-way combinational select of {cmd,ba,addr} by state, with the NOP default. The FSM, grants and `last_rd` stay in `sdram_arbit`.

## Test plan
- Reset, then `init_end` held low for 20 cycles: bus follows `init_cmd`, all grants 0. Raise `init_end`: NOP/2'b11/13'h1fff next cycle.
- `a_ref_req`, `wr_req` and `rd_req` all raised in the same ARBIT cycle: `a_ref_en` next cycle. After `a_ref_end`, one NOP cycle, then `rd_en` (`last_rd`=0).
- `wr_req` and `rd_req` held continuously: grants alternate READ, WRITE, READ, WRITE, with one ARBIT cycle between each.
- `a_ref_req` raised during a 10-cycle write burst: `wr_en` stays 1 until `wr_end`, `a_ref_en` 2 cycles after `wr_end`, `rd_en` never shown meanwhile.
- WRITE with `wr_sdram_en`=1 and data 16'hA5A5: `sdram_dq_oe`=1, `sdram_dq_out`=16'hA5A5. Same inputs in READ state: `sdram_dq_oe`=0, `sdram_dq_out`=0.
- Assert `sys_rst` mid-READ: `rd_en` 0 and state INIT asynchronously. Stray `rd_end` in ARBIT: no state change.
